mod_updown_counter: RTL and testbench

Parametrised modulo up/down counter with synchronous load, count enable, wrap or saturate mode, a registered wrap pulse and a sticky overflow flag. It generalises the team's fixed 3-bit free-running up counter. It is the standard event/timer counter for control paths and is instantiated wherever a bounded count with direction control is needed. An optional compile-time prescaler divides the advance rate.

---
 rtl/counter_pkg.sv | 26 ++
 rtl/counter_prescaler.sv | 38 +++
 rtl/mod_updown_counter.sv | 131 +++++++++++++
 tb/tb_mod_updown_counter.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// counter_pkg
//   Shared constants and helpers for the modulo up/down counter family.
//   - DIR_DOWN / DIR_UP   : encoding of the up_dn input
//   - MODE_WRAP / MODE_SAT: encoding of the sat input
//   - clog2()             : ceiling log2, used to size the prescaler phase register
package counter_pkg;

    localparam logic DIR_DOWN  = 1'b0;
    localparam logic DIR_UP    = 1'b1;
    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

    // Number of bits needed to hold values 0..value-1.
    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/counter_prescaler.sv
// counter_prescaler
//   Divides the counter advance rate. The phase counts 0..PRESCALE-1 on
//   every enabled cycle and holds while en=0; tick is high while the phase
//   sits at PRESCALE-1, so the owner advances once per PRESCALE enabled cycles.
// Ports:
//   clk   in  clock, rising edge
//   reset in  synchronous active-high reset, phase -> 0
//   clr   in  synchronous restart of the period (phase -> 0), wins over en
//   en    in  count enable
//   tick  out high on the last phase of the period
module counter_prescaler
    import counter_pkg::*;
#(
    parameter int PRESCALE = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int            PW   = clog2(PRESCALE);
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] phase_reg;

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            phase_reg <= '0;
        end else if (en) begin
            phase_reg <= (phase_reg == LAST) ? '0 : phase_reg + PW'(1);
        end
    end

    assign tick = (phase_reg == LAST);

endmodule

// File: rtl/mod_updown_counter.sv
// mod_updown_counter
//   Parametrised modulo up/down counter (range 0..MODULUS-1) with synchronous
//   load, count enable, wrap or saturate mode, a registered one-cycle wrap
//   pulse and a sticky overflow flag.
//   Optional feature macro: MOD_UPDOWN_COUNTER_PRESCALE_EN -- when defined, a
//   counter_prescaler makes the counter advance once per PRESCALE enabled
//   cycles; when undefined every enabled cycle advances and PRESCALE is unused
//   apart from its legality check.
// Ports:
//   clk      in  clock, rising edge
//   reset    in  synchronous active-high reset
//   en       in  count enable
//   up_dn    in  1 = up, 0 = down
//   sat      in  1 = saturate at bound, 0 = wrap
//   load     in  synchronous load strobe (clamped to MODULUS-1)
//   load_val in  load value
//   clr_ovf  in  clears ovf (a simultaneous wrap wins)
//   count    out registered count
//   wrap     out registered one-cycle boundary-event pulse
//   at_term  out combinational: count at the terminal value for up_dn
//   ovf      out registered sticky overflow flag
module mod_updown_counter
    import counter_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int MODULUS  = 256,
    parameter int PRESCALE = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up_dn,
    input  logic             sat,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             clr_ovf,
    output logic [WIDTH-1:0] count,
    output logic             wrap,
    output logic             at_term,
    output logic             ovf
);

    generate
        if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_modulus
            $error("mod_updown_counter: MODULUS must lie in 2..2**WIDTH");
        end
        if (PRESCALE < 2) begin : g_bad_prescale
            $error("mod_updown_counter: PRESCALE must be at least 2");
        end
    endgenerate

    // Extended (WIDTH+1 bit) bounds: MODULUS itself can equal 2**WIDTH.
    localparam logic [WIDTH:0] MOD_EXT = (WIDTH + 1)'(MODULUS);
    localparam logic [WIDTH:0] MAX_EXT = (WIDTH + 1)'(MODULUS - 1);

    logic [WIDTH-1:0] count_reg, count_next;
    logic             wrap_reg, wrap_next;
    logic             ovf_reg, ovf_next;
    logic             tick;

    logic [WIDTH:0]   count_ext, inc_ext, dec_ext, load_ext;
    logic             at_max, at_zero, advance, boundary;

`ifdef MOD_UPDOWN_COUNTER_PRESCALE_EN
    // A load restarts the prescale period along with the count.
    counter_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .clr   (load),
        .en    (en),
        .tick  (tick)
    );
`else
    assign tick = 1'b1;
`endif

    assign count_ext = {1'b0, count_reg};
    assign load_ext  = {1'b0, load_val};
    assign inc_ext   = count_ext + (WIDTH + 1)'(1);
    assign dec_ext   = count_ext - (WIDTH + 1)'(1);

    // Upper bound detected when the increment reaches MODULUS; lower bound
    // by the borrow out of the decrement. Neither relies on 2**WIDTH rollover.
    assign at_max    = (inc_ext == MOD_EXT);
    assign at_zero   = dec_ext[WIDTH];
    assign advance   = en & tick;
    assign boundary  = advance & ((up_dn == DIR_UP) ? at_max : at_zero);

    always_comb begin
        count_next = count_reg;
        if (load) begin
            count_next = (load_ext > MAX_EXT) ? MAX_EXT[WIDTH-1:0] : load_val;
        end else if (advance) begin
            if (up_dn == DIR_UP) begin
                if (!at_max)
                    count_next = inc_ext[WIDTH-1:0];
                else if (sat != MODE_SAT)
                    count_next = '0;
            end else begin
                if (!at_zero)
                    count_next = dec_ext[WIDTH-1:0];
                else if (sat != MODE_SAT)
                    count_next = MAX_EXT[WIDTH-1:0];
            end
        end
        // Load outranks advance, so a boundary on a load edge is not an event.
        wrap_next = boundary & ~load;
        // Setting beats a simultaneous clear.
        ovf_next  = wrap_next | (ovf_reg & ~clr_ovf);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_reg <= '0;
            wrap_reg  <= 1'b0;
            ovf_reg   <= 1'b0;
        end else begin
            count_reg <= count_next;
            wrap_reg  <= wrap_next;
            ovf_reg   <= ovf_next;
        end
    end

    assign count   = count_reg;
    assign wrap    = wrap_reg;
    assign ovf     = ovf_reg;
    assign at_term = (up_dn == DIR_UP) ? at_max : at_zero;

endmodule

// File: tb/tb_mod_updown_counter.sv
// tb_mod_updown_counter
//   Self-checking bench for mod_updown_counter (WIDTH=4, MODULUS=10).
//   A behavioural model (plain modulo arithmetic) is advanced on each clock
//   edge from the sampled inputs; each scenario task compares the DUT outputs
//   against it 1 time unit after the edge. Prescaler scenarios are compiled
//   only when MOD_UPDOWN_COUNTER_PRESCALE_EN is defined.
module tb_mod_updown_counter;

    localparam int WIDTH    = 4;
    localparam int MODULUS  = 10;
    localparam int PRESCALE = 4;

    logic             clk = 1'b0;
    logic             reset, en, up_dn, sat, load, clr_ovf;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] count;
    logic             wrap, at_term, ovf;

    int errors = 0;
    int checks = 0;
    int txn    = 0;

    // Reference model state.
    int m_count = 0;
    int m_wrap  = 0;
    int m_ovf   = 0;
    int m_pre   = 0;

    mod_updown_counter #(
        .WIDTH    (WIDTH),
        .MODULUS  (MODULUS),
        .PRESCALE (PRESCALE)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .up_dn    (up_dn),
        .sat      (sat),
        .load     (load),
        .load_val (load_val),
        .clr_ovf  (clr_ovf),
        .count    (count),
        .wrap     (wrap),
        .at_term  (at_term),
        .ovf      (ovf)
    );

    always #5 clk = ~clk;

    task automatic set_in(input logic r, input logic e, input logic u, input logic s,
                          input logic l, input int lv, input logic c);
        reset    = r;
        en       = e;
        up_dn    = u;
        sat      = s;
        load     = l;
        load_val = WIDTH'(lv);
        clr_ovf  = c;
    endtask

    // Advance one clock edge: update the model from the inputs sampled at
    // that edge, then settle and log the transaction.
    task automatic step();
        int  nxt;
        bit  hit;
        bit  tick_v;
        @(posedge clk);
        if (reset) begin
            m_count = 0; m_wrap = 0; m_ovf = 0; m_pre = 0;
        end else if (load) begin
            m_count = (int'(load_val) > MODULUS - 1) ? MODULUS - 1 : int'(load_val);
            m_wrap  = 0;
            m_ovf   = (m_ovf != 0 && !clr_ovf) ? 1 : 0;
            m_pre   = 0;
        end else begin
            tick_v = 1'b1;
`ifdef MOD_UPDOWN_COUNTER_PRESCALE_EN
            tick_v = (m_pre == PRESCALE - 1);
            if (en) m_pre = (m_pre + 1) % PRESCALE;
`endif
            m_wrap = 0;
            if (en && tick_v) begin
                if (up_dn) begin
                    hit = (m_count + 1 >= MODULUS);
                    nxt = (m_count + 1) % MODULUS;
                end else begin
                    hit = (m_count == 0);
                    nxt = (m_count + MODULUS - 1) % MODULUS;
                end
                m_wrap  = hit ? 1 : 0;
                m_count = (hit && sat) ? m_count : nxt;
            end
            m_ovf = (m_wrap != 0 || (m_ovf != 0 && !clr_ovf)) ? 1 : 0;
        end
        #1;
        txn++;
        $display("txn %0d: rst=%0b en=%0b up=%0b sat=%0b ld=%0b lv=%0d clr=%0b -> count=%0d wrap=%0b ovf=%0b term=%0b",
                 txn, reset, en, up_dn, sat, load, load_val, clr_ovf, count, wrap, ovf, at_term);
    endtask

    function automatic logic exp_term();
        return up_dn ? (m_count == MODULUS - 1) : (m_count == 0);
    endfunction

    task automatic test_reset();
        set_in(1, 1, 1, 0, 0, 0, 0);
        step();
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", count); end
        checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL reset_wrap: got %0b want 0", wrap); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %0b want 0", ovf); end
        set_in(0, 1, 1, 0, 0, 0, 0);
        for (int i = 0; i < 7; i++) step();
        checks++; if (count !== WIDTH'(m_count)) begin errors++; $display("FAIL reset_precount: got %0d want %0d", count, m_count); end
        set_in(1, 1, 1, 0, 1, 5, 0);
        step();
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL reset_midcount: got %0d want 0", count); end
    endtask

    task automatic test_up_wrap();
        set_in(0, 1, 1, 0, 0, 0, 0);
        for (int i = 0; i < 12 * PRESCALE; i++) begin
            step();
            checks++; if (count !== WIDTH'(m_count)) begin errors++; $display("FAIL up_wrap_count: got %0d want %0d", count, m_count); end
            checks++; if (wrap !== m_wrap[0]) begin errors++; $display("FAIL up_wrap_wrap: got %0b want %0d", wrap, m_wrap); end
            checks++; if (ovf !== m_ovf[0]) begin errors++; $display("FAIL up_wrap_ovf: got %0b want %0d", ovf, m_ovf); end
            checks++; if (at_term !== exp_term()) begin errors++; $display("FAIL up_wrap_term: got %0b want %0b", at_term, exp_term()); end
        end
        // Sticky while idle, then cleared on a quiet edge.
        set_in(0, 0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step();
        checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL up_wrap_sticky: got %0b want 1", ovf); end
        set_in(0, 0, 1, 0, 0, 0, 1);
        step();
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL up_wrap_clear: got %0b want 0", ovf); end
    endtask

    task automatic test_down_sat();
        set_in(0, 0, 0, 1, 1, 2, 0);
        step();
        set_in(0, 1, 0, 1, 0, 0, 0);
        for (int i = 0; i < 5 * PRESCALE; i++) begin
            step();
            checks++; if (count !== WIDTH'(m_count)) begin errors++; $display("FAIL down_sat_count: got %0d want %0d", count, m_count); end
            checks++; if (wrap !== m_wrap[0]) begin errors++; $display("FAIL down_sat_wrap: got %0b want %0d", wrap, m_wrap); end
            checks++; if (at_term !== exp_term()) begin errors++; $display("FAIL down_sat_term: got %0b want %0b", at_term, exp_term()); end
        end
        checks++; if (count !== 4'd0 || at_term !== 1'b1) begin errors++; $display("FAIL down_sat_end: got count=%0d term=%0b want 0/1", count, at_term); end
    endtask

    task automatic test_load();
        set_in(0, 0, 1, 0, 1, 15, 0);
        step();
        checks++; if (count !== 4'd9) begin errors++; $display("FAIL load_clamp: got %0d want 9", count); end
        set_in(0, 1, 1, 0, 1, 4, 0);
        step();
        checks++; if (count !== 4'd4) begin errors++; $display("FAIL load_over_en: got %0d want 4", count); end
        checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL load_wrap: got %0b want 0", wrap); end
    endtask

    task automatic test_ovf_race();
        set_in(0, 0, 1, 0, 0, 0, 1);
        step();
        set_in(0, 0, 1, 0, 1, 9, 0);
        step();
        set_in(0, 1, 1, 0, 0, 0, 1);
        for (int i = 0; i < PRESCALE * 2 && m_wrap == 0; i++) step();
        checks++; if (wrap !== 1'b1 || ovf !== 1'b1) begin errors++; $display("FAIL ovf_race: got wrap=%0b ovf=%0b want 1/1", wrap, ovf); end
        set_in(0, 0, 1, 0, 0, 0, 1);
        step();
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL ovf_quiet_clear: got %0b want 0", ovf); end
    endtask

`ifdef MOD_UPDOWN_COUNTER_PRESCALE_EN
    task automatic test_prescale();
        set_in(1, 0, 1, 0, 0, 0, 0);
        step();
        set_in(0, 1, 1, 0, 0, 0, 0);
        for (int i = 0; i < 12; i++) step();
        checks++; if (count !== 4'd3) begin errors++; $display("FAIL prescale_rate: got %0d want 3", count); end
        // Phase holds while en is low.
        for (int i = 0; i < 2; i++) step();
        set_in(0, 0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step();
        set_in(0, 1, 1, 0, 0, 0, 0);
        for (int i = 0; i < 2; i++) begin
            step();
            checks++; if (count !== WIDTH'(m_count)) begin errors++; $display("FAIL prescale_hold: got %0d want %0d", count, m_count); end
        end
        // Load restarts the period.
        set_in(0, 1, 1, 0, 1, 1, 0);
        step();
        set_in(0, 1, 1, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            step();
            checks++; if (count !== WIDTH'(m_count)) begin errors++; $display("FAIL prescale_load: got %0d want %0d", count, m_count); end
        end
    endtask
`endif

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            set_in($urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0,
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   $urandom_range(0, 15) == 0, $urandom_range(0, 15),
                   $urandom_range(0, 7) == 0);
            step();
            checks++; if (count !== WIDTH'(m_count)) begin errors++; $display("FAIL rand_count: got %0d want %0d", count, m_count); end
            checks++; if (wrap !== m_wrap[0]) begin errors++; $display("FAIL rand_wrap: got %0b want %0d", wrap, m_wrap); end
            checks++; if (ovf !== m_ovf[0]) begin errors++; $display("FAIL rand_ovf: got %0b want %0d", ovf, m_ovf); end
            checks++; if (at_term !== exp_term()) begin errors++; $display("FAIL rand_term: got %0b want %0b", at_term, exp_term()); end
        end
    endtask

    initial begin
        set_in(1, 0, 1, 0, 0, 0, 0);
        #1;
        test_reset();
        test_up_wrap();
        test_down_sat();
        test_load();
        test_ovf_race();
`ifdef MOD_UPDOWN_COUNTER_PRESCALE_EN
        test_prescale();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
